// File: rtl/blinky_div_sweep.sv
// Multi-channel LED blinker: one prescaler tick feeds a bank of per-channel dividers whose
// ratios {2, 3.5, 4, 5} rotate across channels every SWEEP_TICKS ticks. A synced key pauses all.
module blinky_div_sweep #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PRESCALE    = 12000000,
    parameter int unsigned SWEEP_TICKS = 64,
    parameter bit          INV_BTN     = 1'b0,
    parameter bit          LED_INV     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              key_i,
    output logic [NUM_CH-1:0] led,
    output logic              tick_o,
    output logic [1:0]        mode_o
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SwpW = $clog2(SWEEP_TICKS);
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);
    localparam logic [SwpW-1:0] SwpLast = SwpW'(SWEEP_TICKS - 1);

    logic                   key_meta_q, key_meta_d;
    logic                   pause_q, pause_d;
    logic [PreW-1:0]        pre_cnt_q, pre_cnt_d;
    logic                   tick_q, tick_d;
    logic [SwpW-1:0]        sweep_cnt_q, sweep_cnt_d;
    logic [1:0]             mode_q, mode_d;
    logic [NUM_CH-1:0][2:0] ch_cnt_q, ch_cnt_d;
    logic [NUM_CH-1:0]      phase_q, phase_d;
    logic [NUM_CH-1:0]      level_q, level_d;
    logic                   sweep_wrap;

    // Half-period length in ticks; mode 1 alternates 3/4 to average 3.5.
    function automatic logic [2:0] threshold(input logic [1:0] mode, input logic phase);
        case (mode)
            2'd0:    threshold = 3'd2;
            2'd1:    threshold = phase ? 3'd4 : 3'd3;
            2'd2:    threshold = 3'd4;
            default: threshold = 3'd5;
        endcase
    endfunction

    always_comb begin
        key_meta_d = key_i ^ INV_BTN;
        pause_d    = key_meta_q;

        pre_cnt_d = pre_cnt_q;
        tick_d    = 1'b0;
        if (!pause_q) begin
            tick_d    = (pre_cnt_q == PreLast);
            pre_cnt_d = tick_d ? '0 : pre_cnt_q + 1'b1;
        end
    end

    // A tick already registered before a pause is still consumed, so none is lost on release.
    always_comb begin
        sweep_wrap  = tick_q && (sweep_cnt_q == SwpLast);
        sweep_cnt_d = sweep_cnt_q;
        mode_d      = mode_q;
        if (tick_q) begin
            sweep_cnt_d = sweep_wrap ? '0 : sweep_cnt_q + 1'b1;
            mode_d      = sweep_wrap ? mode_q + 2'd1 : mode_q;
        end
    end

    always_comb begin
        ch_cnt_d = ch_cnt_q;
        phase_d  = phase_q;
        level_d  = level_q;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [1:0] ch_mode;
            ch_mode = mode_q + 2'(c);
            if (tick_q) begin
                if (ch_cnt_q[c] + 3'd1 == threshold(ch_mode, phase_q[c])) begin
                    ch_cnt_d[c] = 3'd0;
                    level_d[c]  = ~level_q[c];
                    if (ch_mode == 2'd1) begin
                        phase_d[c] = ~phase_q[c];
                    end
                end else begin
                    ch_cnt_d[c] = ch_cnt_q[c] + 3'd1;
                end
                // A mode change restarts every divider; the toggle above still lands.
                if (sweep_wrap) begin
                    ch_cnt_d[c] = 3'd0;
                    phase_d[c]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            key_meta_q  <= 1'b0;
            pause_q     <= 1'b0;
            pre_cnt_q   <= '0;
            tick_q      <= 1'b0;
            sweep_cnt_q <= '0;
            mode_q      <= 2'd0;
            ch_cnt_q    <= '0;
            phase_q     <= '0;
            level_q     <= '0;
        end else begin
            key_meta_q  <= key_meta_d;
            pause_q     <= pause_d;
            pre_cnt_q   <= pre_cnt_d;
            tick_q      <= tick_d;
            sweep_cnt_q <= sweep_cnt_d;
            mode_q      <= mode_d;
            ch_cnt_q    <= ch_cnt_d;
            phase_q     <= phase_d;
            level_q     <= level_d;
        end
    end

    assign led    = level_q ^ {NUM_CH{LED_INV}};
    assign tick_o = tick_q;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_blinky_div_sweep.sv
// Directed bench for blinky_div_sweep: a main instance (PRESCALE=4, SWEEP_TICKS=10) plus two
// corner instances (SWEEP_TICKS=64 for the 3.5 cadence; PRESCALE=1 with both inversions).
module tb_blinky_div_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_main_n;
    logic       rst_aux_n;
    logic       key_main;
    logic       key_lo = 1'b0;
    logic       key_hi = 1'b1;
    logic [3:0] led_m, led_s;
    logic [1:0] led_p;
    logic       tick_m, tick_s, tick_p;
    logic [1:0] mode_m, mode_s, mode_p;

    blinky_div_sweep #(
        .NUM_CH(4), .PRESCALE(4), .SWEEP_TICKS(10), .INV_BTN(1'b0), .LED_INV(1'b0)
    ) dut (
        .clk(clk), .rst_i(rst_main_n), .key_i(key_main),
        .led(led_m), .tick_o(tick_m), .mode_o(mode_m)
    );

    blinky_div_sweep #(
        .NUM_CH(4), .PRESCALE(4), .SWEEP_TICKS(64), .INV_BTN(1'b0), .LED_INV(1'b0)
    ) dut_s64 (
        .clk(clk), .rst_i(rst_aux_n), .key_i(key_lo),
        .led(led_s), .tick_o(tick_s), .mode_o(mode_s)
    );

    blinky_div_sweep #(
        .NUM_CH(2), .PRESCALE(1), .SWEEP_TICKS(64), .INV_BTN(1'b1), .LED_INV(1'b1)
    ) dut_p1 (
        .clk(clk), .rst_i(rst_aux_n), .key_i(key_hi),
        .led(led_p), .tick_o(tick_p), .mode_o(mode_p)
    );

    typedef struct {
        int         e;
        logic [3:0] led;
        logic       tick;
        logic [1:0] mode;
    } main_vec_t;

    typedef struct {
        int   e;
        logic led1;
    } s64_vec_t;

    main_vec_t main_tbl[17];
    s64_vec_t  s64_tbl[8];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
        end
    endtask

    initial begin
        rst_main_n = 1'b0;
        rst_aux_n  = 1'b0;
        key_main   = 1'b0;

        main_tbl[0]  = '{1,  4'b0000, 1'b0, 2'd0};
        main_tbl[1]  = '{3,  4'b0000, 1'b0, 2'd0};
        main_tbl[2]  = '{4,  4'b0000, 1'b1, 2'd0};
        main_tbl[3]  = '{5,  4'b0000, 1'b0, 2'd0};
        main_tbl[4]  = '{8,  4'b0000, 1'b1, 2'd0};
        main_tbl[5]  = '{9,  4'b0001, 1'b0, 2'd0};
        main_tbl[6]  = '{12, 4'b0001, 1'b1, 2'd0};
        main_tbl[7]  = '{13, 4'b0011, 1'b0, 2'd0};
        main_tbl[8]  = '{17, 4'b0110, 1'b0, 2'd0};
        main_tbl[9]  = '{21, 4'b1110, 1'b0, 2'd0};
        main_tbl[10] = '{25, 4'b1111, 1'b0, 2'd0};
        main_tbl[11] = '{29, 4'b1101, 1'b0, 2'd0};
        main_tbl[12] = '{33, 4'b1000, 1'b0, 2'd0};
        main_tbl[13] = '{40, 4'b1000, 1'b1, 2'd0};
        main_tbl[14] = '{41, 4'b0011, 1'b0, 2'd1};
        main_tbl[15] = '{49, 4'b1011, 1'b0, 2'd1};
        main_tbl[16] = '{53, 4'b1010, 1'b0, 2'd1};

        s64_tbl[0] = '{12, 1'b0};
        s64_tbl[1] = '{13, 1'b1};
        s64_tbl[2] = '{28, 1'b1};
        s64_tbl[3] = '{29, 1'b0};
        s64_tbl[4] = '{40, 1'b0};
        s64_tbl[5] = '{41, 1'b1};
        s64_tbl[6] = '{56, 1'b1};
        s64_tbl[7] = '{57, 1'b0};

        #12;
        check("rst_main_led", led_m, 4'b0000);
        check("rst_main_tick", tick_m, 1'b0);
        check("rst_main_mode", mode_m, 2'd0);
        check("rst_s64_led", led_s, 4'b0000);
        check("rst_p1_led_inv", led_p, 2'b11);
        check("rst_p1_tick", tick_p, 1'b0);

        // Corner instances: PRESCALE=1 with inverted key/LEDs, and the 3.5 cadence.
        @(posedge clk);
        #1;
        rst_aux_n = 1'b1;
        edge_n    = 0;
        for (int e = 1; e <= 7; e++) begin
            logic       lvl0;
            logic [1:0] exp_led;
            step_to(e);
            lvl0    = 1'(((e - 1) / 2) % 2);
            exp_led = {~(e >= 4), ~lvl0};
            check("p1_tick_high", tick_p, 1'b1);
            check("p1_led", led_p, exp_led);
        end
        for (int i = 0; i < 8; i++) begin
            step_to(s64_tbl[i].e);
            check("s64_led1", led_s[1], s64_tbl[i].led1);
        end
        check("main_held_led", led_m, 4'b0000);
        check("main_held_mode", mode_m, 2'd0);

        rst_main_n = 1'b1;
        edge_n     = 0;
        for (int i = 0; i < 17; i++) begin
            step_to(main_tbl[i].e);
            check("main_led", led_m, main_tbl[i].led);
            check("main_tick", tick_m, main_tbl[i].tick);
            check("main_mode", mode_m, main_tbl[i].mode);
        end

        // Async reset in the middle of a cycle while led=1010.
        #3;
        rst_main_n = 1'b0;
        #1;
        check("async_rst_led", led_m, 4'b0000);
        check("async_rst_mode", mode_m, 2'd0);
        check("async_rst_tick", tick_m, 1'b0);
        #1;
        rst_main_n = 1'b1;
        edge_n     = 0;

        step_to(4);
        check("restart_tick4", tick_m, 1'b1);
        step_to(6);
        key_main = 1'b1;
        step_to(8);
        check("pause_tick8", tick_m, 1'b1);
        check("pause_led8", led_m, 4'b0000);
        for (int e = 9; e <= 33; e++) begin
            step_to(e);
            check("pause_tick_low", tick_m, 1'b0);
            check("pause_led_hold", led_m, 4'b0001);
            if (e == 28) key_main = 1'b0;
        end
        step_to(34);
        check("resume_tick", tick_m, 1'b1);
        check("resume_led34", led_m, 4'b0001);
        step_to(35);
        check("resume_led35", led_m, 4'b0011);
        check("resume_tick35", tick_m, 1'b0);
        step_to(39);
        check("resume_led39", led_m, 4'b0110);
        step_to(62);
        check("sweep1_pre_mode", mode_m, 2'd0);
        check("sweep1_pre_tick", tick_m, 1'b1);
        step_to(63);
        check("sweep1_mode", mode_m, 2'd1);
        step_to(182);
        check("wrap_pre_mode", mode_m, 2'd3);
        check("wrap_pre_tick", tick_m, 1'b1);
        step_to(183);
        check("wrap_mode", mode_m, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
